// File: rtl/spi_regfile_periph.sv
// spi_regfile_periph: SPI mode-0 peripheral exposing a small register file.
// Frame (MSB first): [R/W (1=write)][address][data]; all SPI pins are
// synchronized into clk before use.
// Optional feature macro: SPI_READBACK_EN (read frames return register data on CIPO).
module spi_regfile_periph #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       nCS,
    input  logic                       SCLK,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    localparam int unsigned FRAME_BITS = 1 + ADDR_W + DATA_W;
    localparam int unsigned HDR_BITS   = 1 + ADDR_W;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 2);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, sclk_sync_q, copi_sync_q;
    logic                   ncs_prev_q, sclk_prev_q;
    logic                   ncs_s, sclk_s, copi_s;
    logic                   ncs_rise, ncs_fall, sclk_rise, sclk_fall;
    logic                   clr, shift_en, commit, tx_shift;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]  rx_q, rx_d;
    logic                   rw;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      data;
    logic                   len_ok, addr_ok, wr_en, err;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic                   wr_strobe_q, frame_err_q, cipo_q, cipo_oe_q;
    logic                   cipo_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;

    // Input synchronizers plus one extra stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync_q  <= '1;
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCS};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], COPI};
            ncs_prev_q  <= ncs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_rise  = ~ncs_prev_q & ncs_s;
    assign ncs_fall  = ncs_prev_q & ~ncs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; a chip-select fall seen during COMMIT goes straight to SHIFT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (ncs_fall) state_d = ST_SHIFT;
            ST_SHIFT:  if (ncs_rise) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ncs_fall ? ST_SHIFT : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; SCLK edges coinciding with the chip-select rise are dropped
    always_comb begin
        clr      = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        tx_shift = 1'b0;
        case (state_q)
            ST_IDLE, ST_COMMIT: clr = ncs_fall;
            ST_SHIFT: begin
                shift_en = sclk_rise & ~ncs_rise;
                commit   = ncs_rise;
                // hold the freshly loaded MSB through the falling edge of the last header bit
                tx_shift = sclk_fall & ~ncs_rise & (cnt_q > CNT_W'(HDR_BITS));
            end
            default: ;
        endcase
    end

    assign rw      = rx_q[FRAME_BITS-1];
    assign addr    = rx_q[FRAME_BITS-2 -: ADDR_W];
    assign data    = rx_q[DATA_W-1:0];
    assign len_ok  = (cnt_q == CNT_W'(FRAME_BITS));
    assign addr_ok = ({1'b0, addr} < (ADDR_W+1)'(NUM_REGS));
    assign wr_en   = commit & len_ok & rw & addr_ok;
    assign err     = commit & (~len_ok | (rw & ~addr_ok));

    // Receive shift register, saturating bit counter and write-address hold
    always_comb begin
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        wr_addr_d = wr_addr_q;
        if (clr) begin
            cnt_d = '0;
            rx_d  = '0;
        end else if (shift_en) begin
            rx_d = {rx_q[FRAME_BITS-2:0], copi_s};
            if (cnt_q != CNT_W'(FRAME_BITS + 1)) cnt_d = cnt_q + CNT_W'(1);
        end
        if (wr_en) wr_addr_d = addr;
    end

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] tx_q, tx_d, rd_data;

    // Transmit path: load addressed register once the header is complete on a read
    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (rx_d[ADDR_W-1:0] == ADDR_W'(k)) rd_data = regs_q[k];
        end
        tx_d = tx_q;
        if (clr) begin
            tx_d = '0;
        end else if (shift_en && cnt_q == CNT_W'(HDR_BITS - 1)) begin
            if (!rx_d[ADDR_W]) tx_d = rd_data;
        end else if (tx_shift) begin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end
        cipo_d = tx_d[DATA_W-1] & ~ncs_s;
    end

    // Transmit shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_q <= '0;
        else        tx_q <= tx_d;
    end
`else
    // No readback: CIPO stays low
    always_comb begin
        cipo_d = 1'b0;
    end
`endif

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rx_q        <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            cipo_q      <= 1'b0;
            cipo_oe_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            wr_strobe_q <= wr_en;
            frame_err_q <= err;
            wr_addr_q   <= wr_addr_d;
            cipo_q      <= cipo_d;
            cipo_oe_q   <= ~ncs_s;
        end
    end

    // Register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (wr_en && addr == ADDR_W'(k)) regs_q[k] <= data;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_flat[k*DATA_W +: DATA_W] = regs_q[k];
    end

    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;
    assign wr_addr   = wr_addr_q;
    assign CIPO      = cipo_q;
    assign CIPO_oe   = cipo_oe_q;

endmodule
